// File: rtl/axis_gain_mc.sv
// Multi-channel fixed-point complex gain stage: per-channel signed gain, rescale, saturate.
// Optional round-half-up before the rescale shift when GAIN_MC_ROUND_EN is defined.
module axis_gain_mc #(
   parameter int NUM_CHAN = 1,
   parameter int SAMP_W   = 16,
   parameter int GAIN_W   = 16,
   parameter int FRAC_W   = 0,
   localparam int CHAN_W  = (NUM_CHAN > 1) ? $clog2(NUM_CHAN) : 1,
   localparam int DATA_W  = NUM_CHAN * 2 * SAMP_W
) (
   input  logic              clk,
   input  logic              rst,

   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tlast,
   input  logic              s_axis_tvalid,
   output logic              s_axis_tready,

   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tlast,
   output logic              m_axis_tvalid,
   input  logic              m_axis_tready,

   input  logic              gain_wr_stb,
   input  logic [CHAN_W-1:0] gain_wr_chan,
   input  logic [GAIN_W-1:0] gain_wr_data,
   input  logic [CHAN_W-1:0] gain_rd_chan,
   output logic [GAIN_W-1:0] gain_rd_data,

   output logic [31:0]       clip_cnt,
   input  logic              clip_cnt_clr
);

   localparam int P_W  = SAMP_W + GAIN_W;
   localparam int NC_W = $clog2(2 * NUM_CHAN + 1);

   localparam logic signed [GAIN_W-1:0] UNITY   = GAIN_W'(1) << FRAC_W;
   localparam logic signed [P_W:0]      SAT_MAX = (P_W+1)'((2 ** (SAMP_W-1)) - 1);
   localparam logic signed [P_W:0]      SAT_MIN = (P_W+1)'(-(2 ** (SAMP_W-1)));
`ifdef GAIN_MC_ROUND_EN
   localparam logic signed [P_W:0]      RND     = (P_W+1)'((2 ** FRAC_W) / 2);
`endif

   logic signed [GAIN_W-1:0] pend_gain [NUM_CHAN];
   logic signed [GAIN_W-1:0] pend_nxt  [NUM_CHAN];
   logic signed [GAIN_W-1:0] act_gain  [NUM_CHAN];
   logic [GAIN_W-1:0]        rd_sel;
   logic                     in_pkt;
   logic                     in_pkt_nxt;

   logic en;
   logic accept;

   logic                     v1;
   logic                     l1;
   logic signed [SAMP_W-1:0] s1_i [NUM_CHAN];
   logic signed [SAMP_W-1:0] s1_q [NUM_CHAN];
   logic signed [GAIN_W-1:0] g1   [NUM_CHAN];

   logic                     v2;
   logic                     l2;
   logic signed [P_W-1:0]    p2_i [NUM_CHAN];
   logic signed [P_W-1:0]    p2_q [NUM_CHAN];

   logic [DATA_W-1:0]        y_data;
   logic [NC_W-1:0]          n_clip;
   logic [32:0]              clip_sum;

   assign en            = ~m_axis_tvalid | m_axis_tready;
   assign s_axis_tready = en & ~rst;
   assign accept        = s_axis_tvalid & s_axis_tready;

   // Returns {clipped, saturated sample} for one rescaled product.
   function automatic logic [SAMP_W:0] scale(input logic signed [P_W-1:0] p);
      logic signed [P_W:0] pr;
      logic signed [P_W:0] sh;
      pr = (P_W+1)'(p);
`ifdef GAIN_MC_ROUND_EN
      pr = pr + RND;
`endif
      sh = pr >>> FRAC_W;
      if (sh > SAT_MAX)
         scale = {1'b1, SAT_MAX[SAMP_W-1:0]};
      else if (sh < SAT_MIN)
         scale = {1'b1, SAT_MIN[SAMP_W-1:0]};
      else
         scale = {1'b0, sh[SAMP_W-1:0]};
   endfunction

   always_comb begin
      in_pkt_nxt = in_pkt;
      if (accept)
         in_pkt_nxt = ~s_axis_tlast;
      rd_sel = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         pend_nxt[c] = pend_gain[c];
         if (gain_wr_stb && (gain_wr_chan == CHAN_W'(c)))
            pend_nxt[c] = gain_wr_data;
         if (gain_rd_chan == CHAN_W'(c))
            rd_sel = pend_nxt[c];
      end
   end

   // Active bank only tracks pending while idle, so a packet never sees a gain change.
   always_ff @(posedge clk) begin
      if (rst) begin
         in_pkt       <= 1'b0;
         gain_rd_data <= UNITY;
         for (int c = 0; c < NUM_CHAN; c++) begin
            pend_gain[c] <= UNITY;
            act_gain[c]  <= UNITY;
         end
      end else begin
         in_pkt       <= in_pkt_nxt;
         gain_rd_data <= rd_sel;
         for (int c = 0; c < NUM_CHAN; c++) begin
            pend_gain[c] <= pend_nxt[c];
            if (!in_pkt_nxt)
               act_gain[c] <= pend_nxt[c];
         end
      end
   end

   always_comb begin
      logic [SAMP_W:0] res_i;
      logic [SAMP_W:0] res_q;
      y_data = '0;
      n_clip = '0;
      for (int c = 0; c < NUM_CHAN; c++) begin
         res_i = scale(p2_i[c]);
         res_q = scale(p2_q[c]);
         y_data[2*SAMP_W*c +: 2*SAMP_W] = {res_i[SAMP_W-1:0], res_q[SAMP_W-1:0]};
         n_clip = n_clip + NC_W'(res_i[SAMP_W]) + NC_W'(res_q[SAMP_W]);
      end
   end

   // Gain is snapshotted with the beat so the tail of a packet is immune to the bank reload.
   always_ff @(posedge clk) begin
      if (rst) begin
         v1            <= 1'b0;
         l1            <= 1'b0;
         v2            <= 1'b0;
         l2            <= 1'b0;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         m_axis_tdata  <= '0;
         for (int c = 0; c < NUM_CHAN; c++) begin
            s1_i[c] <= '0;
            s1_q[c] <= '0;
            g1[c]   <= '0;
            p2_i[c] <= '0;
            p2_q[c] <= '0;
         end
      end else if (en) begin
         v1            <= accept;
         l1            <= s_axis_tlast;
         v2            <= v1;
         l2            <= l1;
         m_axis_tvalid <= v2;
         m_axis_tlast  <= l2;
         m_axis_tdata  <= y_data;
         for (int c = 0; c < NUM_CHAN; c++) begin
            s1_i[c] <= s_axis_tdata[2*SAMP_W*c+SAMP_W +: SAMP_W];
            s1_q[c] <= s_axis_tdata[2*SAMP_W*c +: SAMP_W];
            g1[c]   <= act_gain[c];
            p2_i[c] <= P_W'(s1_i[c]) * P_W'(g1[c]);
            p2_q[c] <= P_W'(s1_q[c]) * P_W'(g1[c]);
         end
      end
   end

   assign clip_sum = {1'b0, clip_cnt} + 33'(n_clip);

   always_ff @(posedge clk) begin
      if (rst || clip_cnt_clr)
         clip_cnt <= '0;
      else if (en && v2)
         clip_cnt <= clip_sum[32] ? 32'hFFFF_FFFF : clip_sum[31:0];
   end

endmodule

// File: tb/tb_axis_gain_mc.sv
// Randomized self-checking bench for axis_gain_mc (2 channels, 16-bit samples/gains, 4 fraction bits).
module tb_axis_gain_mc;

   localparam int NC = 2;
   localparam int SW = 16;
   localparam int GW = 16;
   localparam int FW = 4;
   localparam int DW = NC * 2 * SW;
   localparam int UNITY = 1 << FW;
   localparam int MAXV = (1 << (SW-1)) - 1;
   localparam int MINV = -(1 << (SW-1));

   logic          clk = 1'b0;
   logic          rst;
   logic [DW-1:0] s_axis_tdata;
   logic          s_axis_tlast;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [DW-1:0] m_axis_tdata;
   logic          m_axis_tlast;
   logic          m_axis_tvalid;
   logic          m_axis_tready;
   logic          gain_wr_stb;
   logic [0:0]    gain_wr_chan;
   logic [GW-1:0] gain_wr_data;
   logic [0:0]    gain_rd_chan;
   logic [GW-1:0] gain_rd_data;
   logic [31:0]   clip_cnt;
   logic          clip_cnt_clr;

   always #5 clk = ~clk;

   axis_gain_mc #(.NUM_CHAN(NC), .SAMP_W(SW), .GAIN_W(GW), .FRAC_W(FW)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tlast  (s_axis_tlast),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .gain_wr_stb   (gain_wr_stb),
      .gain_wr_chan  (gain_wr_chan),
      .gain_wr_data  (gain_wr_data),
      .gain_rd_chan  (gain_rd_chan),
      .gain_rd_data  (gain_rd_data),
      .clip_cnt      (clip_cnt),
      .clip_cnt_clr  (clip_cnt_clr)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: packet-level gain sets and plain integer arithmetic.
   typedef struct {
      logic [DW-1:0] d;
      logic          l;
   } beat_t;

   int            pend [NC];
   int            pkt_g [NC];
   bit            mdl_in_pkt;
   longint        mdl_clip;
   beat_t         expq [$];
   int            in_cnt;
   int            out_cnt;
   logic [DW-1:0] last_out;
   logic [GW-1:0] exp_rd;
   bit            stall_prev;
   logic [DW-1:0] stall_d;
   logic          stall_l;
   bit            rand_ready = 1'b0;

   function automatic int ref_comp(input int x, input int g, inout int nclip);
      longint p;
      p = longint'(x) * longint'(g);
`ifdef GAIN_MC_ROUND_EN
      p = p + ((longint'(1) <<< FW) / 2);
`endif
      p = p >>> FW;
      if (p > MAXV) begin
         nclip++;
         p = MAXV;
      end else if (p < MINV) begin
         nclip++;
         p = MINV;
      end
      return int'(p);
   endfunction

   function automatic logic [DW-1:0] ref_beat(input logic [DW-1:0] x, inout int nclip);
      logic [DW-1:0] r;
      int xi, xq, yi, yq;
      r = '0;
      for (int c = 0; c < NC; c++) begin
         xi = int'($signed(x[2*SW*c+SW +: SW]));
         xq = int'($signed(x[2*SW*c +: SW]));
         yi = ref_comp(xi, pkt_g[c], nclip);
         yq = ref_comp(xq, pkt_g[c], nclip);
         r[2*SW*c+SW +: SW] = SW'(yi);
         r[2*SW*c +: SW]    = SW'(yq);
      end
      return r;
   endfunction

   always @(negedge clk) begin
      beat_t e;
      int    nclip;
      if (rst) begin
         expq.delete();
         for (int c = 0; c < NC; c++) pend[c] = UNITY;
         mdl_in_pkt = 1'b0;
         mdl_clip   = 0;
         exp_rd     = GW'(UNITY);
         stall_prev = 1'b0;
         in_cnt     = 0;
         out_cnt    = 0;
         check("rst_tready", 64'(s_axis_tready), 64'd0);
      end else begin
         check("rd_data", 64'(gain_rd_data), 64'(exp_rd));
         if (stall_prev) begin
            check("stall_valid", 64'(m_axis_tvalid), 64'd1);
            check("stall_data", {m_axis_tlast, m_axis_tdata[62:0]}, {stall_l, stall_d[62:0]});
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (expq.size() == 0) begin
               check("spurious_out", 64'd1, 64'd0);
            end else begin
               e = expq.pop_front();
               check("out_data", m_axis_tdata, e.d);
               check("out_last", 64'(m_axis_tlast), 64'(e.l));
               out_cnt++;
               last_out = m_axis_tdata;
            end
         end
         stall_prev = m_axis_tvalid && !m_axis_tready;
         stall_d    = m_axis_tdata;
         stall_l    = m_axis_tlast;
         if (s_axis_tvalid && s_axis_tready) begin
            if (!mdl_in_pkt)
               for (int c = 0; c < NC; c++) pkt_g[c] = pend[c];
            nclip = 0;
            e.d = ref_beat(s_axis_tdata, nclip);
            e.l = s_axis_tlast;
            expq.push_back(e);
            mdl_clip = mdl_clip + nclip;
            if (mdl_clip > 64'hFFFF_FFFF) mdl_clip = 64'hFFFF_FFFF;
            mdl_in_pkt = !s_axis_tlast;
            in_cnt++;
         end
         if (clip_cnt_clr) mdl_clip = 0;
         if (gain_wr_stb) pend[gain_wr_chan] = int'($signed(gain_wr_data));
         exp_rd = GW'(pend[gain_rd_chan]);
      end
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [DW-1:0] d, input logic l, input bit wr,
                            input int wch, input int wg, input bit gaps);
      bit acc;
      if (gaps) repeat ($urandom_range(0, 1)) tick();
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = d;
      s_axis_tlast  = l;
      gain_wr_stb   = wr;
      gain_wr_chan  = 1'(wch);
      gain_wr_data  = GW'(wg);
      acc = 1'b0;
      for (int k = 0; k < 1000; k++) begin
         @(negedge clk);
         acc = s_axis_tready;
         tick();
         gain_wr_stb = 1'b0;
         if (acc) break;
      end
      if (!acc) check("send_timeout", 64'd0, 64'd1);
      s_axis_tvalid = 1'b0;
      s_axis_tlast  = 1'b0;
   endtask

   task automatic send_pkt(input int len, input int mode, input int wr_at, input int wch,
                           input int wg, input bit gaps);
      logic [DW-1:0] d;
      for (int i = 1; i <= len; i++) begin
         if (mode == 1) d = {4{16'd1000}};
         else           d = {$urandom, $urandom};
         send_beat(d, i == len, i == wr_at, wch, wg, gaps);
      end
   endtask

   task automatic write_gain(input int ch, input int g);
      gain_wr_stb  = 1'b1;
      gain_wr_chan = 1'(ch);
      gain_wr_data = GW'(g);
      tick();
      gain_wr_stb  = 1'b0;
   endtask

   task automatic drain();
      rand_ready = 1'b0;
      for (int k = 0; k < 500; k++) begin
         if (expq.size() == 0 && !m_axis_tvalid) break;
         tick();
      end
      tick();
      check("drain_empty", 64'(expq.size()), 64'd0);
      check("beat_count", 64'(out_cnt), 64'(in_cnt));
   endtask

   initial begin
      int lat, sent, len;
      rst           = 1'b1;
      s_axis_tdata  = '0;
      s_axis_tlast  = 1'b0;
      s_axis_tvalid = 1'b0;
      gain_wr_stb   = 1'b0;
      gain_wr_chan  = '0;
      gain_wr_data  = '0;
      gain_rd_chan  = '0;
      clip_cnt_clr  = 1'b0;
      repeat (3) tick();
      rst = 1'b0;

      @(negedge clk);
      check("reset_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("reset_tdata", m_axis_tdata, 64'd0);
      check("reset_tlast", 64'(m_axis_tlast), 64'd0);
      check("reset_clip", 64'(clip_cnt), 64'd0);
      check("reset_rd", 64'(gain_rd_data), 64'(UNITY));
      check("reset_tready", 64'(s_axis_tready), 64'd1);
      tick();

      // pipeline latency with output always ready
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = {$urandom, $urandom};
      s_axis_tlast  = 1'b1;
      @(negedge clk);
      check("lat_accept", 64'(s_axis_tready), 64'd1);
      tick();
      s_axis_tvalid = 1'b0;
      lat = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         lat++;
         if (m_axis_tvalid) break;
      end
      check("latency", 64'(lat), 64'd3);
      drain();

      // unity gain, back-to-back 64-beat packet
      in_cnt = 0;
      out_cnt = 0;
      send_pkt(64, 0, 0, 0, 0, 1'b0);
      drain();
      check("unity_beats", 64'(out_cnt), 64'd64);

      // saturation and clip counting
      write_gain(0, -UNITY);
      send_beat({32'h0, 16'h8000, 16'd100}, 1'b1, 1'b0, 0, 0, 1'b0);
      drain();
      check("neg_clip_i", 64'(int'($signed(last_out[31:16]))), 64'(MAXV));
      check("neg_q", 64'(int'($signed(last_out[15:0]))), 64'(-100));
      check("clip_cnt_1", 64'(clip_cnt), 64'd1);
      write_gain(0, 256 * UNITY);
      send_beat({32'h0, 16'd255, 16'd0}, 1'b1, 1'b0, 0, 0, 1'b0);
      drain();
      check("big_clip_i", 64'(int'($signed(last_out[31:16]))), 64'(MAXV));
      check("clip_cnt_2", 64'(clip_cnt), 64'd2);
      clip_cnt_clr = 1'b1;
      tick();
      clip_cnt_clr = 1'b0;
      tick();
      check("clip_clr", 64'(clip_cnt), 64'd0);

      // fractional gain 0.5 on +/-3
      write_gain(0, UNITY / 2);
      send_beat({32'h0, 16'd3, 16'hFFFD}, 1'b1, 1'b0, 0, 0, 1'b0);
      drain();
`ifdef GAIN_MC_ROUND_EN
      check("frac_i", 64'(int'($signed(last_out[31:16]))), 64'(2));
      check("frac_q", 64'(int'($signed(last_out[15:0]))), 64'(-1));
`else
      check("frac_i", 64'(int'($signed(last_out[31:16]))), 64'(1));
      check("frac_q", 64'(int'($signed(last_out[15:0]))), 64'(-2));
`endif

      // gain write mid-packet deferred to the next packet
      write_gain(0, UNITY);
      write_gain(1, UNITY);
      send_pkt(64, 1, 10, 0, 37, 1'b0);
      drain();
      check("defer_old", 64'(int'($signed(last_out[31:16]))), 64'(1000));
      check("rd_new", 64'(gain_rd_data), 64'd37);
      send_pkt(4, 1, 0, 0, 0, 1'b0);
      drain();
      check("defer_new", 64'(int'($signed(last_out[31:16]))), 64'((1000 * 37) >>> FW));

      // random valid/ready toggling, gains 5 / -22
      clip_cnt_clr = 1'b1;
      tick();
      clip_cnt_clr = 1'b0;
      write_gain(0, 5 * UNITY);
      write_gain(1, -22 * UNITY);
      gain_rd_chan = 1'b1;
      rand_ready = 1'b1;
      sent = 0;
      while (sent < 1000) begin
         len = $urandom_range(1, 40);
         if (sent + len > 1000) len = 1000 - sent;
         send_pkt(len, 0, 0, 0, 0, 1'b1);
         sent += len;
      end
      drain();
      check("rand_clip", 64'(clip_cnt), 64'(mdl_clip));

      // random gain writes landing inside packets
      rand_ready = 1'b1;
      sent = 0;
      while (sent < 300) begin
         len = $urandom_range(1, 20);
         gain_rd_chan = 1'($urandom_range(0, 1));
         send_pkt(len, 0, $urandom_range(1, len), $urandom_range(0, 1),
                  int'($urandom_range(0, 65535)) - 32768, 1'b1);
         sent += len;
      end
      drain();
      check("rand2_clip", 64'(clip_cnt), 64'(mdl_clip));

      // reset with two beats of an open packet in flight
      gain_rd_chan = 1'b0;
      write_gain(0, 3 * UNITY);
      send_beat({$urandom, $urandom}, 1'b0, 1'b0, 0, 0, 1'b0);
      send_beat({$urandom, $urandom}, 1'b0, 1'b0, 0, 0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("mrst_tvalid", 64'(m_axis_tvalid), 64'd0);
      check("mrst_rd", 64'(gain_rd_data), 64'(UNITY));
      check("mrst_clip", 64'(clip_cnt), 64'd0);
      check("mrst_tready", 64'(s_axis_tready), 64'd1);
      tick();
      send_pkt(8, 0, 0, 0, 0, 1'b0);
      write_gain(0, 2 * UNITY);
      send_pkt(8, 0, 0, 0, 0, 1'b0);
      drain();
      check("mrst_beats", 64'(out_cnt), 64'd16);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
